// File: rtl/topic_bias.sv
// Topic-driven score biasing: per-pair bias registers fed by topic votes, plus a
// sequential biased-argmax scan. Optional bias decay is enabled by TOPIC_BIAS_DECAY_EN.
module topic_bias #(
   parameter int SCORE_W  = 8,
   parameter int BIAS_MAX = 15,
   parameter int BIAS_THR = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 delta_tick,
   input  logic [2:0]           topic_winner,
   input  logic [2:0]           topic_strength,
   input  logic                 topic_valid,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6*SCORE_W-1:0] in_score,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [6*SCORE_W-1:0] out_biased,
   output logic [2:0]           out_winner,
   output logic [SCORE_W-1:0]   out_max
);

   // state | meaning
   // IDLE  | waiting for a score vector, in_ready high
   // SCAN  | r_idx 0..5 adds bias per pair; r_idx 1..6 compares the previous sum
   // DONE  | result held on out_* until out_ready
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

`ifdef TOPIC_BIAS_DECAY_EN
   localparam bit DECAY_EN = 1'b1;
`else
   localparam bit DECAY_EN = 1'b0;
`endif

   localparam logic [2:0] THR  = 3'(BIAS_THR);
   localparam logic [4:0] BMAX = 5'(BIAS_MAX);

   state_t               r_state, w_next;
   logic                 r_delta_d;
   logic [3:0]           r_bias      [6];
   logic [3:0]           r_snap_bias [6];
   logic [6*SCORE_W-1:0] r_snap_score;
   logic [2:0]           r_idx;
   logic [SCORE_W-1:0]   r_sum;
   logic [6*SCORE_W-1:0] r_out_biased;
   logic [2:0]           r_out_winner;
   logic [SCORE_W-1:0]   r_out_max;

   logic                 w_in_ready, w_out_valid, w_accept;
   logic                 w_inc;
   logic [3:0]           w_win_bias, w_inc_val;
   logic [4:0]           w_add;
   logic [SCORE_W-1:0]   w_score, w_biased;
   logic [3:0]           w_bias;
   logic [SCORE_W:0]     w_tot;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) w_next = SCAN;
         end
         SCAN: if (r_idx == 3'd6) w_next = DONE;
         DONE: begin
            w_out_valid = 1'b1;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_accept = in_valid && w_in_ready;

   // Bias increment path: only the winner's register can grow on a given delta.
   always_comb begin
      w_win_bias = 4'd0;
      for (int i = 0; i < 6; i++)
         if (topic_winner == 3'(i)) w_win_bias = r_bias[i];
   end

   assign w_inc     = topic_valid && (topic_strength >= THR) && (topic_winner <= 3'd5);
   assign w_add     = {1'b0, w_win_bias} + {2'b00, topic_strength};
   assign w_inc_val = (w_add > BMAX) ? BMAX[3:0] : w_add[3:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_delta_d <= 1'b0;
         for (int i = 0; i < 6; i++) r_bias[i] <= 4'd0;
      end else begin
         r_delta_d <= delta_tick;
         if (r_delta_d) begin
            for (int i = 0; i < 6; i++) begin
               if (w_inc && topic_winner == 3'(i))
                  r_bias[i] <= w_inc_val;
               else if (DECAY_EN && r_bias[i] != 4'd0)
                  r_bias[i] <= r_bias[i] - 4'd1;
            end
         end
      end
   end

   // Shared saturating adder, fed from the snapshot so in-flight bias updates are ignored.
   always_comb begin
      w_score = '0;
      w_bias  = 4'd0;
      for (int i = 0; i < 6; i++) begin
         if (r_idx == 3'(i)) begin
            w_score = r_snap_score[i*SCORE_W +: SCORE_W];
            w_bias  = r_snap_bias[i];
         end
      end
   end

   assign w_tot    = {1'b0, w_score} + {{(SCORE_W-3){1'b0}}, w_bias};
   assign w_biased = w_tot[SCORE_W] ? {SCORE_W{1'b1}} : w_tot[SCORE_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_snap_score <= '0;
         for (int i = 0; i < 6; i++) r_snap_bias[i] <= 4'd0;
         r_idx        <= 3'd0;
         r_sum        <= '0;
         r_out_biased <= '0;
         r_out_winner <= 3'd0;
         r_out_max    <= '0;
      end else begin
         if (w_accept) begin
            r_snap_score <= in_score;
            for (int i = 0; i < 6; i++) r_snap_bias[i] <= r_bias[i];
            r_idx <= 3'd0;
         end
         if (r_state == SCAN) begin
            r_idx <= r_idx + 3'd1;
            if (r_idx <= 3'd5) begin
               r_sum <= w_biased;
               for (int i = 0; i < 6; i++)
                  if (r_idx == 3'(i)) r_out_biased[i*SCORE_W +: SCORE_W] <= w_biased;
            end
            // Strictly-greater replace keeps ties on the lowest index.
            if (r_idx != 3'd0 && (r_idx == 3'd1 || r_sum > r_out_max)) begin
               r_out_max    <= r_sum;
               r_out_winner <= r_idx - 3'd1;
            end
         end
      end
   end

   assign in_ready   = w_in_ready;
   assign out_valid  = w_out_valid;
   assign out_biased = r_out_biased;
   assign out_winner = r_out_winner;
   assign out_max    = r_out_max;

endmodule

// File: doc/topic_bias.md
TOPIC_BIAS -- requirements
Module: topic_bias

Interface
REQ-001 SHALL have parameter SCORE_W, default 8, width of each per-pair score.
REQ-002 SHALL have parameter BIAS_MAX, default 15, saturation ceiling of each 4-bit bias register.
REQ-003 SHALL have parameter BIAS_THR, default 3, minimum topic_strength that grants a bias increment.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port delta_tick  input  1  delta-episode boundary pulse, one cycle wide.
REQ-007 SHALL have port topic_winner  input  3  dominant pair index from the topic stage.
REQ-008 SHALL have port topic_strength  input  3  vote count of topic_winner.
REQ-009 SHALL have port topic_valid  input  1  topic outputs meaningful.
REQ-010 SHALL have port in_valid  input  1  score vector offered.
REQ-011 SHALL have port in_ready  output  1  block can accept a score vector.
REQ-012 SHALL have port in_score  input  6*SCORE_W  pair p in bits [p*SCORE_W +: SCORE_W].
REQ-013 SHALL have port out_valid  output  1  biased result held.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-015 SHALL have port out_biased  output  6*SCORE_W  biased scores, same packing as in_score.
REQ-016 SHALL have port out_winner  output  3  argmax pair of out_biased.
REQ-017 SHALL have port out_max  output  SCORE_W  value of out_biased at out_winner.

Function
REQ-018 SHALL hold six 4-bit bias registers bias_0..bias_5.
REQ-019 SHALL register delta_tick into delta_d and perform bias updates on the cycle delta_d=1, so they see topic outputs already refreshed by the same tick.
REQ-020 On delta_d: if topic_valid, topic_strength>=BIAS_THR and topic_winner<=5, bias[topic_winner] SHALL become min(bias+topic_strength, BIAS_MAX); if topic_winner>5, no increment.
REQ-021 SHALL implement FSM states IDLE, SCAN, DONE; in_ready=1 only in IDLE.
REQ-022 IDLE->SCAN on in_valid&&in_ready; in_score and all six biases SHALL be snapshotted that cycle; later bias updates do not affect the current vector.
REQ-023 SCAN SHALL process one pair per cycle, idx 0..5, via one shared adder: biased=min(score+bias, 2^SCORE_W-1).
REQ-024 Running argmax SHALL replace only on strictly greater; ties go to the lowest index; idx 0 initialises the max.
REQ-025 SCAN->DONE after idx 5; out_valid SHALL rise exactly 7 cycles after the accept edge.
REQ-026 In DONE, out_* SHALL stay stable while out_valid=1 and out_ready=0; DONE->IDLE on out_ready; out_valid drops the next cycle.
REQ-027 A delta_d coinciding with accept, SCAN or DONE SHALL update the biases without stalling the FSM.

Reset
REQ-028 rst SHALL force IDLE, bias_0..5=0, delta_d=0, out_valid=0, out_biased=0, out_winner=0, out_max=0, in_ready=1 after release, regardless of state, including mid-SCAN.

Configuration
REQ-029 Macro TOPIC_BIAS_DECAY_EN: when defined, on every delta_d each bias not incremented by REQ-020 SHALL decrement by 1, floor 0, including when no increment occurs; when undefined, non-incremented biases hold.

Verification
REQ-030 Reset, then accept in_score all pairs=10 -> out_valid 7 cycles later, out_winner=0, out_max=10.
REQ-031 delta_tick with topic_valid=1, winner=2, strength=4, then accept all 10 -> out_biased pair2=14, out_winner=2, out_max=14.
REQ-032 Four deltas with winner=5, strength=5 -> bias_5=15 saturated; pair5 score 250 -> out_max=255.
REQ-033 strength=2 (<BIAS_THR), winner=1 -> no bias change; with TOPIC_BIAS_DECAY_EN and bias_1=3 beforehand, bias_1=2.
REQ-034 Hold out_ready=0 for 5 cycles in DONE -> out_* stable, in_ready=0; a delta mid-SCAN leaves the current result unchanged.
REQ-035 Assert rst at SCAN idx 3 -> out_valid=0, biases=0, IDLE; next vector processed normally.
